mrv32_decode_issue: RTL and testbench
=====================================

// Module: mrv32_decode_issue
// PURPOSE
// - RV32I decode/issue stage between fetch and execute; drives rs1/rs2 addresses to the register file.
// - Captures operands, immediate and control into a 1-entry ID/EX pipeline register.
// - A 32-bit busy scoreboard stalls RAW/WAW hazards.
// - Writeback data is bypassed into captured operands because RF read-during-write is undefined.
// PARAMETERS
// - XLEN      32        datapath width; only 32 is supported
// - RESET_PC  32'h0     reset value of id_pc
// PORTS
// - clk         in   1   clock, all state updates on rising edge
// - rst         in   1   synchronous, active-high reset
// - if_valid    in   1   fetch presents an instruction
// - if_ready    out  1   stage accepts the instruction this cycle
// - if_instr    in   32  instruction word
// - if_pc       in   32  PC of if_instr
// - rs1_addr    out  5   RF read address 1 (= if_instr[19:15])
// - rs2_addr    out  5   RF read address 2 (= if_instr[24:20])
// - rs1_data    in   32  RF read data 1, combinational
// - rs2_data    in   32  RF read data 2, combinational
// - wb_wen      in   1   writeback write enable (same signal as RF write enable)
// - wb_rd       in   5   writeback destination
// - wb_data     in   32  writeback data
// - flush       in   1   kill ID/EX entry (branch redirect)
// - id_valid    out  1   ID/EX entry valid
// - id_ready    in   1   execute consumes the entry
// - id_pc, id_instr          out  32  captured PC / instruction
// - id_rs1_val, id_rs2_val   out  32  captured operands (0 when the field is unused)
// - id_imm      out  32  sign-extended immediate
// - id_rd       out  5   destination register
// - id_rd_wen   out  1   instruction writes rd (rd!=0)
// - id_illegal  out  1   unsupported opcode
// BEHAVIOUR
// - Reset values:
//   - id_valid=0; busy=0; id_pc=RESET_PC; all other id_* = 0.
// - Format by opcode:
//   - R 0110011; I 0010011/0000011/1100111; S 0100011; B 1100011; U 0110111/0010111; J 1101111.
//   - FENCE 0001111 = legal, no rd write.
//   - Any other opcode: id_illegal=1, id_rd_wen=0.
// - Field use:
//   - rs1 used by all formats except U and J.
//   - rs2 used by R, S and B only.
//   - rd written by R, I, U and J when rd!=0.
// - Hazard on rsX:
//   - Condition: used & rsX!=0 & busy[rsX] & !(wb_wen & wb_rd==rsX).
// - WAW hazard:
//   - Condition: rd_wen & busy[rd] & !(wb_wen & wb_rd==rd).
// - Ready and accept:
//   - if_ready = (!id_valid | id_ready) & !hazard & !flush.
//   - Accept = if_valid & if_ready; ID/EX loads on the next edge (1-cycle latency).
// - Bypass:
//   - Operand = wb_data when wb_wen & wb_rd==rsX & rsX!=0.
//   - Otherwise operand = rsX_data; unused operand = 0.
// - Scoreboard:
//   - Clear busy[wb_rd] on wb_wen & wb_rd!=0.
//   - Set busy[rd] on accept & rd_wen.
//   - Same reg set+clear in one cycle: set wins.
//   - busy[0] is never set.
// - id_valid next:
//   - flush -> 0, and clear busy[id_rd] when id_valid & id_rd_wen.
//   - else accept -> 1.
//   - else id_ready -> 0.
//   - else hold.
// - Payload:
//   - Stable while id_valid & !id_ready.
//   - No combinational path from id_ready to id_* payload.
// - Reset mid-operation: the entry is dropped and all busy bits are cleared; the in-flight writeback is ignored.
// STRUCTURE
// - mrv32_pkg:
//   - opcode localparams (OP_LUI...OP_FENCE).
//   - typedef enum imm_fmt_e {FMT_R,FMT_I,FMT_S,FMT_B,FMT_U,FMT_J,FMT_NONE}.
// - Sub-module mrv32_imm_gen:
//   - Combinational; instr + imm_fmt_e -> 32-bit immediate.
//   - B/J bit0=0; U low 12 bits = 0.
// - Top: decode comb, hazard/bypass comb, ID/EX register, busy register.
// TESTING
// - ADDI x1,x0,5 (0x00500093), id_ready=1:
//   - id_valid next cycle, id_rd=1, id_imm=5, busy[1]=1.
// - ADD x2,x1,x1 right after, x1 busy, no wb:
//   - if_ready=0.
//   - wb_wen=1,wb_rd=1,wb_data=5 that cycle -> accepted, id_rs1_val=id_rs2_val=5.
// - id_ready=0 for 3 cycles with a valid entry:
//   - Payload unchanged; if_ready=0.
//   - Release -> the next instruction loads on the following edge.
// - flush with entry ADDI x3 valid:
//   - id_valid=0 next cycle, busy[3]=0, no instruction accepted that cycle.
// - Opcode 1110011 accepted:
//   - id_illegal=1, id_rd_wen=0, busy unchanged.
// - BEQ x0,x0,-4 (0xFE000EE3):
//   - id_imm=32'hFFFFFFFC, id_rd_wen=0.
//   - Reset asserted during the stall -> id_valid=0 and busy=0 after 1 edge.

Source files
------------

// File: rtl/mrv32_pkg.sv
// Shared RV32I decode definitions: base opcodes and the immediate format selector.
// Used by the decode/issue stage and its immediate generator.
package mrv32_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

endpackage

// File: rtl/mrv32_imm_gen.sv
// RV32I immediate extraction; purely combinational, zero latency, no flow control.
// The opcode bits are not needed here, so only instr[31:7] is taken.
module mrv32_imm_gen
    import mrv32_pkg::*;
(
    input  logic [31:7] instr,
    input  imm_fmt_e    fmt,
    output logic [31:0] imm
);

    always_comb begin
        imm = 32'd0;
        unique case (fmt)
            FMT_I: imm = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm = {instr[31:12], 12'd0};
            FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/mrv32_decode_issue.sv
// RV32I decode/issue: 1-cycle latency into a single ID/EX entry with a busy scoreboard.
// if_ready drops on RAW/WAW hazard, flush, or a full entry that execute is not consuming.
module mrv32_decode_issue
    import mrv32_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [31:0]     if_instr,
    input  logic [31:0]     if_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            wb_wen,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_pc,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [31:0]     id_imm,
    output logic [4:0]      id_rd,
    output logic            id_rd_wen,
    output logic            id_illegal
);

    logic [6:0]      opcode;
    logic [4:0]      rd;
    imm_fmt_e        fmt;
    logic            legal;
    logic            rs1_used, rs2_used, rd_wen;
    logic            haz_rs1, haz_rs2, haz_waw, hazard, accept;
    logic [XLEN-1:0] op1, op2;
    logic [31:0]     imm;

    logic            id_valid_q,   id_valid_d;
    logic [31:0]     id_pc_q,      id_pc_d;
    logic [31:0]     id_instr_q,   id_instr_d;
    logic [XLEN-1:0] id_rs1_val_q, id_rs1_val_d;
    logic [XLEN-1:0] id_rs2_val_q, id_rs2_val_d;
    logic [31:0]     id_imm_q,     id_imm_d;
    logic [4:0]      id_rd_q,      id_rd_d;
    logic            id_rd_wen_q,  id_rd_wen_d;
    logic            id_illegal_q, id_illegal_d;
    logic [31:0]     busy_q,       busy_d;

    assign opcode   = if_instr[6:0];
    assign rd       = if_instr[11:7];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    always_comb begin
        fmt   = FMT_NONE;
        legal = 1'b1;
        unique case (opcode)
            OP_OP:                    fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
            OP_STORE:                 fmt = FMT_S;
            OP_BRANCH:                fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            OP_FENCE:                 fmt = FMT_NONE;
            default:                  legal = 1'b0;
        endcase
    end

    assign rs1_used = (fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_S) || (fmt == FMT_B);
    assign rs2_used = (fmt == FMT_R) || (fmt == FMT_S) || (fmt == FMT_B);
    assign rd_wen   = ((fmt == FMT_R) || (fmt == FMT_I) || (fmt == FMT_U) || (fmt == FMT_J))
                      && (rd != 5'd0);

    mrv32_imm_gen u_imm_gen (
        .instr (if_instr[31:7]),
        .fmt   (fmt),
        .imm   (imm)
    );

    // A register being written back this cycle is no longer a hazard: its value comes from wb_data.
    assign haz_rs1 = rs1_used && (rs1_addr != 5'd0) && busy_q[rs1_addr]
                     && !(wb_wen && (wb_rd == rs1_addr));
    assign haz_rs2 = rs2_used && (rs2_addr != 5'd0) && busy_q[rs2_addr]
                     && !(wb_wen && (wb_rd == rs2_addr));
    assign haz_waw = rd_wen && busy_q[rd] && !(wb_wen && (wb_rd == rd));
    assign hazard  = haz_rs1 || haz_rs2 || haz_waw;

    assign if_ready = (!id_valid_q || id_ready) && !hazard && !flush;
    assign accept   = if_valid && if_ready;

    always_comb begin
        op1 = '0;
        op2 = '0;
        if (rs1_used) begin
            op1 = (wb_wen && (wb_rd == rs1_addr) && (rs1_addr != 5'd0)) ? wb_data : rs1_data;
        end
        if (rs2_used) begin
            op2 = (wb_wen && (wb_rd == rs2_addr) && (rs2_addr != 5'd0)) ? wb_data : rs2_data;
        end
    end

    always_comb begin
        busy_d = busy_q;
        if (wb_wen && (wb_rd != 5'd0)) begin
            busy_d[wb_rd] = 1'b0;
        end
        // A killed entry will never write back, so release its destination.
        if (flush && id_valid_q && id_rd_wen_q) begin
            busy_d[id_rd_q] = 1'b0;
        end
        if (accept && rd_wen) begin
            busy_d[rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_comb begin
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        id_rs1_val_d = id_rs1_val_q;
        id_rs2_val_d = id_rs2_val_q;
        id_imm_d     = id_imm_q;
        id_rd_d      = id_rd_q;
        id_rd_wen_d  = id_rd_wen_q;
        id_illegal_d = id_illegal_q;
        if (flush) begin
            id_valid_d = 1'b0;
        end else if (accept) begin
            id_valid_d = 1'b1;
        end else if (id_ready) begin
            id_valid_d = 1'b0;
        end
        if (accept) begin
            id_pc_d      = if_pc;
            id_instr_d   = if_instr;
            id_rs1_val_d = op1;
            id_rs2_val_d = op2;
            id_imm_d     = imm;
            id_rd_d      = rd;
            id_rd_wen_d  = rd_wen && legal;
            id_illegal_d = !legal;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_q   <= 1'b0;
            id_pc_q      <= RESET_PC;
            id_instr_q   <= '0;
            id_rs1_val_q <= '0;
            id_rs2_val_q <= '0;
            id_imm_q     <= '0;
            id_rd_q      <= '0;
            id_rd_wen_q  <= 1'b0;
            id_illegal_q <= 1'b0;
            busy_q       <= '0;
        end else begin
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            id_rs1_val_q <= id_rs1_val_d;
            id_rs2_val_q <= id_rs2_val_d;
            id_imm_q     <= id_imm_d;
            id_rd_q      <= id_rd_d;
            id_rd_wen_q  <= id_rd_wen_d;
            id_illegal_q <= id_illegal_d;
            busy_q       <= busy_d;
        end
    end

    assign id_valid   = id_valid_q;
    assign id_pc      = id_pc_q;
    assign id_instr   = id_instr_q;
    assign id_rs1_val = id_rs1_val_q;
    assign id_rs2_val = id_rs2_val_q;
    assign id_imm     = id_imm_q;
    assign id_rd      = id_rd_q;
    assign id_rd_wen  = id_rd_wen_q;
    assign id_illegal = id_illegal_q;

endmodule

// File: tb/tb_mrv32_decode_issue.sv
// Directed bench for the decode/issue stage: hazards, bypass, backpressure, flush, reset.
module tb_mrv32_decode_issue;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_wen;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        id_valid, id_ready;
    logic [31:0] id_pc, id_instr, id_rs1_val, id_rs2_val, id_imm;
    logic [4:0]  id_rd;
    logic        id_rd_wen, id_illegal;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // Register file stand-in: x0 reads zero, every other register reads a recognisable non-zero value.
    assign rs1_data = (rs1_addr == 5'd0) ? 32'd0 : (32'hA000_0000 | {27'd0, rs1_addr});
    assign rs2_data = (rs2_addr == 5'd0) ? 32'd0 : (32'hB000_0000 | {27'd0, rs2_addr});

    mrv32_decode_issue #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_valid   (if_valid),
        .if_ready   (if_ready),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .wb_wen     (wb_wen),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .flush      (flush),
        .id_valid   (id_valid),
        .id_ready   (id_ready),
        .id_pc      (id_pc),
        .id_instr   (id_instr),
        .id_rs1_val (id_rs1_val),
        .id_rs2_val (id_rs2_val),
        .id_imm     (id_imm),
        .id_rd      (id_rd),
        .id_rd_wen  (id_rd_wen),
        .id_illegal (id_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        n_chk++;
        if (obs === exp_val) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end
    endtask

    // Advance one edge, then settle inputs/outputs 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        if_valid = 1'b1;
        if_instr = instr;
        if_pc    = pc;
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        if_valid = 1'b0;
        if_instr = 32'd0;
        if_pc    = 32'd0;
        wb_wen   = 1'b0;
        wb_rd    = 5'd0;
        wb_data  = 32'd0;
        flush    = 1'b0;
        id_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_busy", dut.busy_q, 32'd0);
        chk("rst_id_imm", id_imm, 32'd0);

        // ADDI x1,x0,5
        drive(32'h00500093, 32'h100);
        chk("addi_if_ready", {31'd0, if_ready}, 32'd1);
        step();
        chk("addi_id_valid", {31'd0, id_valid}, 32'd1);
        chk("addi_id_rd", {27'd0, id_rd}, 32'd1);
        chk("addi_id_imm", id_imm, 32'd5);
        chk("addi_id_rd_wen", {31'd0, id_rd_wen}, 32'd1);
        chk("addi_busy", dut.busy_q, 32'h0000_0002);

        // ADD x2,x1,x1 while x1 busy and no writeback: stall
        drive(32'h00108133, 32'h104);
        chk("add_rs1_addr", {27'd0, rs1_addr}, 32'd1);
        chk("add_rs2_addr", {27'd0, rs2_addr}, 32'd1);
        chk("add_stall", {31'd0, if_ready}, 32'd0);
        step();
        chk("add_stall_drain", {31'd0, id_valid}, 32'd0);
        wb_wen  = 1'b1;
        wb_rd   = 5'd1;
        wb_data = 32'd5;
        #1;
        chk("add_wb_ready", {31'd0, if_ready}, 32'd1);
        step();
        wb_wen = 1'b0;
        chk("add_rs1_byp", id_rs1_val, 32'd5);
        chk("add_rs2_byp", id_rs2_val, 32'd5);
        chk("add_id_rd", {27'd0, id_rd}, 32'd2);
        chk("add_busy", dut.busy_q, 32'h0000_0004);

        // Backpressure: ADD entry held, ADDI x3,x0,7 waits
        id_ready = 1'b0;
        drive(32'h00700193, 32'h108);
        for (int i = 0; i < 3; i++) begin
            chk("bp_if_ready", {31'd0, if_ready}, 32'd0);
            step();
            chk("bp_id_pc", id_pc, 32'h104);
            chk("bp_id_instr", id_instr, 32'h00108133);
            chk("bp_id_valid", {31'd0, id_valid}, 32'd1);
        end
        id_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, if_ready}, 32'd1);
        step();
        chk("bp_next_pc", id_pc, 32'h108);
        chk("bp_next_imm", id_imm, 32'd7);
        chk("bp_next_busy", dut.busy_q, 32'h0000_000C);

        // Flush with ADDI x3 in the entry; ADDI x4 offered but must not be taken
        id_ready = 1'b0;
        flush    = 1'b1;
        drive(32'h00900213, 32'h10C);
        chk("flush_if_ready", {31'd0, if_ready}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush_id_valid", {31'd0, id_valid}, 32'd0);
        chk("flush_busy", dut.busy_q, 32'h0000_0004);
        chk("flush_pc_kept", id_pc, 32'h108);

        // SYSTEM opcode 1110011, rd=x5: illegal
        id_ready = 1'b1;
        drive(32'h000002F3, 32'h110);
        chk("ill_if_ready", {31'd0, if_ready}, 32'd1);
        step();
        chk("ill_id_illegal", {31'd0, id_illegal}, 32'd1);
        chk("ill_id_rd_wen", {31'd0, id_rd_wen}, 32'd0);
        chk("ill_busy", dut.busy_q, 32'h0000_0004);

        // BEQ x0,x0,-4
        drive(32'hFE000EE3, 32'h114);
        step();
        chk("beq_id_imm", id_imm, 32'hFFFF_FFFC);
        chk("beq_id_rd_wen", {31'd0, id_rd_wen}, 32'd0);
        chk("beq_id_illegal", {31'd0, id_illegal}, 32'd0);

        // ADD x6,x2,x0 stalls on busy x2; reset lands during the stall with a writeback in flight
        id_ready = 1'b0;
        drive(32'h00010333, 32'h118);
        chk("rst_stall_ready", {31'd0, if_ready}, 32'd0);
        rst     = 1'b1;
        wb_wen  = 1'b1;
        wb_rd   = 5'd7;
        wb_data = 32'h1234;
        step();
        chk("midrst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("midrst_busy", dut.busy_q, 32'd0);
        chk("midrst_id_pc", id_pc, 32'h0);
        rst      = 1'b0;
        wb_wen   = 1'b0;
        id_ready = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, if_ready}, 32'd1);
        step();
        chk("post_rst_pc", id_pc, 32'h118);
        chk("post_rst_rs1", id_rs1_val, 32'hA000_0002);
        chk("post_rst_rs2", id_rs2_val, 32'd0);

        // LUI x8,0x12345: rs1 field is 8 but unused, so operand is zero
        drive(32'h12345437, 32'h11C);
        step();
        chk("lui_imm", id_imm, 32'h1234_5000);
        chk("lui_rs1_zero", id_rs1_val, 32'd0);
        chk("lui_busy", dut.busy_q, 32'h0000_0140);

        if_valid = 1'b0;
        step();
        chk("idle_id_valid", {31'd0, id_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
